// File: rtl/rs232_event_capture.sv
// RS-232 sniffer front end: line sync, change stamping, ping-pong record banks.
// Optional RS232_DROP_COUNT_EN adds a saturating drop_count output.
`timescale 1ns/1ps
module rs232_event_capture #(
  parameter int LINES      = 8,
  parameter int TS_WIDTH   = 24,
  parameter int BANK_BYTES = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LINES-1:0] lines_in,
  output logic [LINES-1:0] lines_out,
  input  logic             flush,
  input  logic [8:0]       rd_addr,
  output logic [7:0]       rd_data,
  output logic             bank_ready,
  output logic [9:0]       bank_len,
  input  logic             bank_done,
  output logic             overflow,
  input  logic             clear_overflow
`ifdef RS232_DROP_COUNT_EN
  ,
  output logic [15:0]      drop_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0] CNT_ONE = 1;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [TS_WIDTH-1:0] TS_ONE = 1;
  localparam logic [9:0] BANK_LEN = 10'(BANK_BYTES);

  typedef enum logic [2:0] {
    IDLE, W0, W1, W2, W3, SWAP
  } state_t;

  logic [LINES-1:0]    sync1, sync2, prev;
  logic [TS_WIDTH-1:0] ts;
  logic [31:0]         rec_new;
  logic                change;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty;
  logic          push, pop, drop;
  logic [31:0]   head;

  state_t     state;
  logic [9:0] count, count_nxt;
  logic       fill_bank, rd_bank, flush_pend;

  logic       wr_en;
  logic [1:0] wr_idx;
  logic [7:0] wr_byte;
  logic [8:0] wr_addr;
  logic [7:0] bank_mem [2*BANK_BYTES];

  assign lines_out = sync2;
  assign change    = (sync2 != prev);

  always_comb begin
    rec_new = '0;
    rec_new[24 +: LINES] = sync2;
    rec_new[0 +: TS_WIDTH] = ts;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      ts    <= '0;
    end else begin
      sync1 <= lines_in;
      sync2 <= sync1;
      prev  <= sync2;
      ts    <= ts + TS_ONE;
    end
  end

  assign fifo_full  = (fifo_cnt == CNT_FULL);
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = change && !fifo_full;
  assign drop       = change && fifo_full;
  assign pop        = (state == W3);
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rec_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_ONE;
      else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_ONE;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = 2'd0;
    wr_byte = head[31:24];
    unique case (state)
      W0: begin wr_en = 1'b1; wr_idx = 2'd0; wr_byte = head[31:24]; end
      W1: begin wr_en = 1'b1; wr_idx = 2'd1; wr_byte = head[23:16]; end
      W2: begin wr_en = 1'b1; wr_idx = 2'd2; wr_byte = head[15:8];  end
      W3: begin wr_en = 1'b1; wr_idx = 2'd3; wr_byte = head[7:0];   end
      default: ;
    endcase
  end

  assign wr_addr   = count[8:0] + {7'd0, wr_idx};
  assign count_nxt = count + 10'd4;

  always_ff @(posedge clk) begin
    if (wr_en) bank_mem[{fill_bank, wr_addr}] <= wr_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= bank_mem[{rd_bank, rd_addr}];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      fill_bank  <= 1'b0;
      rd_bank    <= 1'b0;
      flush_pend <= 1'b0;
      bank_ready <= 1'b0;
      bank_len   <= '0;
    end else begin
      if (bank_done && bank_ready) bank_ready <= 1'b0;
      if (flush && (count != '0 || !fifo_empty)) flush_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (!fifo_empty && count != BANK_LEN) state <= W0;
          else if (flush_pend && count != '0)   state <= SWAP;
        end
        W0: state <= W1;
        W1: state <= W2;
        W2: state <= W3;
        W3: begin
          count <= count_nxt;
          if (count_nxt == BANK_LEN || flush_pend || flush) state <= SWAP;
          else state <= IDLE;
        end
        SWAP: begin
          // the swap cycle wins over a flush arriving in the same clk
          if (!bank_ready) begin
            bank_ready <= 1'b1;
            bank_len   <= count;
            rd_bank    <= fill_bank;
            fill_bank  <= ~fill_bank;
            count      <= '0;
            flush_pend <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

`ifdef RS232_DROP_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               drop_count <= '0;
    else if (clear_overflow) drop_count <= drop ? 16'd1 : 16'd0;
    else if (drop && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule
